// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared control encodings and helpers for the memory stage
package memory_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MEN_X = 2'd0,
        MEN_S = 2'd1,
        MEN_L = 2'd2
    } men_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef struct packed {
        logic [4:0]      rd_addr;
        logic            rf_wen;
        men_e            mem_wen;
        size_e           mem_size;
        logic            mem_sign;
        logic [XLEN-1:0] rs2_data;
    } ctrltype;

    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/memory_stage_align.sv
// rtl/memory_stage_align.sv - store lane replication/byte enables and load extract/extend
module mem_data_align
    import memory_stage_pkg::*;
(
    input  size_e       size_i,
    input  logic        sign_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wmask_o,
    output logic [31:0] load_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        wdata_o = rs2_i;
        wmask_o = 4'b1111;
        load_o  = rdata_i;
        case (size_i)
            SZ_B: begin
                wdata_o = {4{rs2_i[7:0]}};
                wmask_o = 4'b0001 << off_i;
                load_o  = {{24{sign_i & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                wdata_o = {2{rs2_i[15:0]}};
                wmask_o = 4'b0011 << off_i;
                load_o  = {{16{sign_i & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - load/store stage between execute and write-back
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        exe_mem_valid,
    input  logic [31:0] exe_mem_reg_pc,
    input  logic [31:0] exe_mem_inst,
    input  logic [63:0] exe_mem_inst_id,
    input  ctrltype     exe_mem_ctrl,
    input  logic [31:0] exe_mem_alu_out,
    output logic        mem_wb_valid,
    output logic [31:0] mem_wb_reg_pc,
    output logic [31:0] mem_wb_inst,
    output logic [63:0] mem_wb_inst_id,
    output ctrltype     mem_wb_ctrl,
    output logic [31:0] mem_wb_alu_out,
    output logic [31:0] mem_wb_rdata,
    output logic        mem_wb_misaligned,
    output logic        mem_stall_flg,
    input  logic        pipeline_flush,
    output logic        dreq_valid,
    input  logic        dreq_ready,
    output logic [31:0] dreq_addr,
    output logic        dreq_wen,
    output logic [31:0] dreq_wdata,
    output logic [3:0]  dreq_wmask,
    input  logic        dresp_valid,
    input  logic [31:0] dresp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RESP,
        S_DONE,
        S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_mem;
    logic        misaligned;
    logic        mem_access;
    logic [31:0] align_wdata;
    logic [3:0]  align_wmask;
    logic [31:0] load_fmt;

    assign is_mem     = exe_mem_ctrl.mem_wen != MEN_X;
    assign misaligned = is_misaligned(exe_mem_ctrl.mem_size, exe_mem_alu_out[1:0]);
    assign mem_access = exe_mem_valid && is_mem && !misaligned;

    mem_data_align u_align (
        .size_i  (exe_mem_ctrl.mem_size),
        .sign_i  (exe_mem_ctrl.mem_sign),
        .off_i   (exe_mem_alu_out[1:0]),
        .rs2_i   (exe_mem_ctrl.rs2_data),
        .rdata_i (dresp_rdata),
        .wdata_o (align_wdata),
        .wmask_o (align_wmask),
        .load_o  (load_fmt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_access && !pipeline_flush && dreq_ready) begin
                    state_d = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                // A flushed access still owes one response; DRAIN swallows it unless it is already here.
                if (pipeline_flush) begin
                    state_d = dresp_valid ? S_IDLE : S_DRAIN;
                end else if (dresp_valid) begin
                    state_d = S_DONE;
                    rdata_d = (exe_mem_ctrl.mem_wen == MEN_L) ? load_fmt : 32'h0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_DRAIN: begin
                if (dresp_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dreq_valid        = 1'b0;
        mem_wb_valid      = 1'b0;
        mem_wb_rdata      = 32'h0;
        mem_wb_misaligned = 1'b0;
        mem_stall_flg     = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_IDLE: begin
                    dreq_valid        = mem_access && !pipeline_flush;
                    mem_wb_valid      = exe_mem_valid && !pipeline_flush && (!is_mem || misaligned);
                    mem_wb_misaligned = exe_mem_valid && !pipeline_flush && is_mem && misaligned;
                end
                S_DONE: begin
                    mem_wb_valid = !pipeline_flush;
                    mem_wb_rdata = rdata_q;
                end
                default: ;
            endcase
            mem_stall_flg = (mem_access && (state_q != S_DONE)) || (state_q == S_DRAIN);
        end
    end

    assign mem_wb_reg_pc  = exe_mem_reg_pc;
    assign mem_wb_inst    = exe_mem_inst;
    assign mem_wb_inst_id = exe_mem_inst_id;
    assign mem_wb_ctrl    = exe_mem_ctrl;
    assign mem_wb_alu_out = exe_mem_alu_out;

    assign dreq_addr  = {exe_mem_alu_out[31:2], 2'b00};
    assign dreq_wen   = exe_mem_ctrl.mem_wen == MEN_S;
    assign dreq_wdata = align_wdata;
    assign dreq_wmask = dreq_wen ? align_wmask : 4'b0000;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        exe_mem_valid;
    logic [31:0] exe_mem_reg_pc;
    logic [31:0] exe_mem_inst;
    logic [63:0] exe_mem_inst_id;
    ctrltype     exe_mem_ctrl;
    logic [31:0] exe_mem_alu_out;
    logic        mem_wb_valid;
    logic [31:0] mem_wb_reg_pc;
    logic [31:0] mem_wb_inst;
    logic [63:0] mem_wb_inst_id;
    ctrltype     mem_wb_ctrl;
    logic [31:0] mem_wb_alu_out;
    logic [31:0] mem_wb_rdata;
    logic        mem_wb_misaligned;
    logic        mem_stall_flg;
    logic        pipeline_flush;
    logic        dreq_valid;
    logic        dreq_ready;
    logic [31:0] dreq_addr;
    logic        dreq_wen;
    logic [31:0] dreq_wdata;
    logic [3:0]  dreq_wmask;
    logic        dresp_valid;
    logic [31:0] dresp_rdata;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .reset(reset),
        .exe_mem_valid(exe_mem_valid), .exe_mem_reg_pc(exe_mem_reg_pc), .exe_mem_inst(exe_mem_inst),
        .exe_mem_inst_id(exe_mem_inst_id), .exe_mem_ctrl(exe_mem_ctrl), .exe_mem_alu_out(exe_mem_alu_out),
        .mem_wb_valid(mem_wb_valid), .mem_wb_reg_pc(mem_wb_reg_pc), .mem_wb_inst(mem_wb_inst),
        .mem_wb_inst_id(mem_wb_inst_id), .mem_wb_ctrl(mem_wb_ctrl), .mem_wb_alu_out(mem_wb_alu_out),
        .mem_wb_rdata(mem_wb_rdata), .mem_wb_misaligned(mem_wb_misaligned), .mem_stall_flg(mem_stall_flg),
        .pipeline_flush(pipeline_flush),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr), .dreq_wen(dreq_wen),
        .dreq_wdata(dreq_wdata), .dreq_wmask(dreq_wmask),
        .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Byte-addressed memory model; the stage's lanes and masks are derived from it, not mirrored.
    logic [7:0] mem_b [int unsigned];

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return mem_b.exists(a) ? mem_b[a] : 8'h00;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = rd_byte((a & 32'hFFFF_FFFC) + 32'(k));
        return w;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) mem_b[a + 32'(k)] = w[8*k +: 8];
    endtask

    function automatic int nbytes(input size_e s);
        return (s == SZ_B) ? 1 : (s == SZ_H) ? 2 : 4;
    endfunction

    function automatic ctrltype mk(input men_e w, input size_e s, input logic sgn, input logic [31:0] rs2);
        ctrltype c;
        c          = '0;
        c.rd_addr  = 5'd7;
        c.rf_wen   = (w != MEN_S);
        c.mem_wen  = w;
        c.mem_size = s;
        c.mem_sign = sgn;
        c.rs2_data = rs2;
        return c;
    endfunction

    typedef struct { logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] wmask; } req_t;
    typedef struct { logic [31:0] pc; logic [63:0] id; logic [31:0] alu; logic [31:0] rdata; logic mis; } wb_t;
    req_t req_q[$];
    wb_t  wb_q[$];

    task automatic model_push(input ctrltype c, input logic [31:0] addr, input logic [31:0] pc,
                              input logic [63:0] id, input bit expect_wb);
        req_t r;
        wb_t  e;
        int   n;
        n       = nbytes(c.mem_size);
        e.pc    = pc;
        e.id    = id;
        e.alu   = addr;
        e.rdata = 32'h0;
        e.mis   = 1'b0;
        if (c.mem_wen != MEN_X) begin
            if ((addr % n) != 0) begin
                e.mis = 1'b1;
            end else begin
                r.addr  = addr & 32'hFFFF_FFFC;
                r.wen   = (c.mem_wen == MEN_S);
                r.wdata = c.rs2_data;
                r.wmask = 4'b0000;
                if (r.wen) begin
                    for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = c.rs2_data[8*(i % n) +: 8];
                    for (int k = 0; k < n; k++) begin
                        r.wmask[(addr % 4) + k] = 1'b1;
                        mem_b[addr + 32'(k)]    = c.rs2_data[8*k +: 8];
                    end
                end else begin
                    for (int k = 0; k < n; k++) e.rdata[8*k +: 8] = rd_byte(addr + 32'(k));
                    if (c.mem_sign && n < 4 && e.rdata[8*n-1])
                        for (int k = n; k < 4; k++) e.rdata[8*k +: 8] = 8'hFF;
                end
                req_q.push_back(r);
            end
        end
        if (expect_wb) wb_q.push_back(e);
    endtask

    // Memory responder: one response per accepted request, resp_lat cycles after the handshake.
    int          resp_lat = 1;
    int          cyc = 0;
    int          hs_count = 0;
    int          hs_cyc = 0;
    int          resp_cyc = -1;
    int          prev_resp_cyc = -1;
    int          req_cycles = 0;
    bit          busy = 1'b0;
    int          cnt = 0;
    logic [31:0] resp_word = 32'h0;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_wmask;
    logic        last_wen;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        dresp_valid = 1'b0;
        dresp_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset && dreq_valid && dreq_ready) begin
                chk("single_outstanding", {63'h0, busy}, 64'h0);
                busy          = 1'b1;
                cnt           = resp_lat;
                resp_word     = rd_word(dreq_addr);
                prev_resp_cyc = resp_cyc;
                hs_cyc        = cyc;
                hs_count++;
                last_addr  = dreq_addr;
                last_wdata = dreq_wdata;
                last_wmask = dreq_wmask;
                last_wen   = dreq_wen;
            end
            @(posedge clk);
            #2;
            dresp_valid = 1'b0;
            dresp_rdata = 32'h0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    dresp_valid = 1'b1;
                    dresp_rdata = resp_word;
                    busy        = 1'b0;
                    resp_cyc    = cyc;
                end
            end
        end
    end

    // Scoreboard compare against the model on every handshake and every write-back.
    always @(negedge clk) begin
        if (!reset) begin
            if (dreq_valid) req_cycles++;
            if (dreq_valid && dreq_ready) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_request", {32'h0, dreq_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("req_addr", {32'h0, dreq_addr}, {32'h0, r.addr});
                    chk("req_wen", {63'h0, dreq_wen}, {63'h0, r.wen});
                    chk("req_wmask", {60'h0, dreq_wmask}, {60'h0, r.wmask});
                    if (r.wen) chk("req_wdata", {32'h0, dreq_wdata}, {32'h0, r.wdata});
                end
            end
            if (mem_wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk("unexpected_wb", mem_wb_inst_id, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    wb_t e;
                    e = wb_q.pop_front();
                    chk("wb_pc", {32'h0, mem_wb_reg_pc}, {32'h0, e.pc});
                    chk("wb_id", mem_wb_inst_id, e.id);
                    chk("wb_alu", {32'h0, mem_wb_alu_out}, {32'h0, e.alu});
                    chk("wb_rdata", {32'h0, mem_wb_rdata}, {32'h0, e.rdata});
                    chk("wb_misaligned", {63'h0, mem_wb_misaligned}, {63'h0, e.mis});
                    chk("wb_no_stall", {63'h0, mem_stall_flg}, 64'h0);
                end
            end
        end
    end

    int seq = 0;

    task automatic present(input ctrltype c, input logic [31:0] addr, input bit expect_wb);
        seq++;
        model_push(c, addr, 32'h1000 + 32'(seq * 4), {32'hC0DE_0000, 32'(seq)}, expect_wb);
        exe_mem_valid   = 1'b1;
        exe_mem_ctrl    = c;
        exe_mem_alu_out = addr;
        exe_mem_reg_pc  = 32'h1000 + 32'(seq * 4);
        exe_mem_inst    = $urandom;
        exe_mem_inst_id = {32'hC0DE_0000, 32'(seq)};
    endtask

    // Presents one instruction and holds it while the stage stalls, as the EX register would.
    task automatic issue(input ctrltype c, input logic [31:0] addr,
                         output int stalls, output logic [31:0] wb_rdata, output bit wb_seen);
        bit done;
        present(c, addr, 1'b1);
        stalls   = 0;
        wb_rdata = 32'h0;
        wb_seen  = 1'b0;
        done     = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (mem_wb_valid) begin
                wb_seen  = 1'b1;
                wb_rdata = mem_wb_rdata;
            end
            if (!mem_stall_flg) done = 1'b1;
            else stalls++;
        end
        if (!done) chk("issue_timeout", 64'h1, 64'h0);
        @(posedge clk);
        #2;
        exe_mem_valid = 1'b0;
    endtask

    int          st;
    logic [31:0] rd;
    bit          seen;
    int          hs0, rq0, wbv;

    initial begin
        reset          = 1'b1;
        pipeline_flush = 1'b0;
        dreq_ready     = 1'b1;
        exe_mem_valid  = 1'b1;
        exe_mem_ctrl   = mk(MEN_L, SZ_W, 1'b0, 32'h0);
        exe_mem_alu_out = 32'h100;
        exe_mem_reg_pc  = 32'h0;
        exe_mem_inst    = 32'h0;
        exe_mem_inst_id = 64'h0;
        repeat (2) @(negedge clk);
        chk("reset_dreq_valid", {63'h0, dreq_valid}, 64'h0);
        chk("reset_wb_valid", {63'h0, mem_wb_valid}, 64'h0);
        chk("reset_stall", {63'h0, mem_stall_flg}, 64'h0);
        chk("reset_rdata", {32'h0, mem_wb_rdata}, 64'h0);
        @(posedge clk);
        #2;
        reset         = 1'b0;
        exe_mem_valid = 1'b0;
        @(posedge clk);
        #2;

        issue(mk(MEN_X, SZ_W, 1'b0, 32'h5), 32'h1234_5678, st, rd, seen);
        chk("alu_stalls", 64'(st), 64'd0);
        chk("alu_wb_seen", {63'h0, seen}, 64'h1);

        set_word(32'h100, 32'hDEAD_BEEF);
        issue(mk(MEN_L, SZ_W, 1'b0, 32'h0), 32'h100, st, rd, seen);
        chk("lw_stalls", 64'(st), 64'd2);
        chk("lw_rdata", {32'h0, rd}, 64'hDEAD_BEEF);

        set_word(32'h100, 32'h80FF_FFFF);
        issue(mk(MEN_L, SZ_B, 1'b1, 32'h0), 32'h103, st, rd, seen);
        chk("lb_rdata", {32'h0, rd}, 64'hFFFF_FF80);
        issue(mk(MEN_L, SZ_B, 1'b0, 32'h0), 32'h103, st, rd, seen);
        chk("lbu_rdata", {32'h0, rd}, 64'h0000_0080);
        set_word(32'h100, 32'hABCD_0000);
        issue(mk(MEN_L, SZ_H, 1'b0, 32'h0), 32'h102, st, rd, seen);
        chk("lhu_rdata", {32'h0, rd}, 64'h0000_ABCD);

        issue(mk(MEN_S, SZ_H, 1'b0, 32'h1234_5678), 32'h206, st, rd, seen);
        chk("sh_addr", {32'h0, last_addr}, 64'h204);
        chk("sh_wdata", {32'h0, last_wdata}, 64'h5678_5678);
        chk("sh_wmask", {60'h0, last_wmask}, 64'hC);
        chk("sh_wen", {63'h0, last_wen}, 64'h1);
        chk("sh_stalls", 64'(st), 64'd2);
        chk("sh_done_seen", {63'h0, seen}, 64'h1);

        rq0 = req_cycles;
        issue(mk(MEN_L, SZ_W, 1'b0, 32'h0), 32'h101, st, rd, seen);
        chk("mis_stalls", 64'(st), 64'd0);
        chk("mis_wb_seen", {63'h0, seen}, 64'h1);
        chk("mis_no_request", 64'(req_cycles - rq0), 64'd0);

        dreq_ready = 1'b0;
        hs0 = hs_count;
        fork
            issue(mk(MEN_S, SZ_B, 1'b0, 32'h0000_00AB), 32'h205, st, rd, seen);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("hold_valid", {63'h0, dreq_valid}, 64'h1);
                    chk("hold_fields", {dreq_addr, dreq_wdata}, {32'h204, 32'hABAB_ABAB});
                    chk("hold_mask", {59'h0, dreq_wen, dreq_wmask}, {59'h0, 1'b1, 4'b0010});
                    chk("hold_stall", {63'h0, mem_stall_flg}, 64'h1);
                end
                @(posedge clk);
                #2;
                dreq_ready = 1'b1;
            end
        join
        chk("hold_stalls", 64'(st), 64'd5);
        chk("hold_one_handshake", 64'(hs_count - hs0), 64'd1);

        resp_lat = 3;
        issue(mk(MEN_L, SZ_W, 1'b0, 32'h0), 32'h204, st, rd, seen);
        chk("lw_after_stores", {32'h0, rd}, 64'h5678_AB00);
        chk("lw_lat3_stalls", 64'(st), 64'd4);
        resp_lat = 1;

        issue(mk(MEN_S, SZ_W, 1'b0, 32'h8001_7FFF), 32'h300, st, rd, seen);
        issue(mk(MEN_L, SZ_H, 1'b1, 32'h0), 32'h302, st, rd, seen);
        chk("lh_signed", {32'h0, rd}, 64'hFFFF_8001);
        issue(mk(MEN_L, SZ_B, 1'b1, 32'h0), 32'h301, st, rd, seen);
        issue(mk(MEN_L, SZ_H, 1'b0, 32'h0), 32'h300, st, rd, seen);

        // Flush while waiting: response 4 cycles after the flush is drained, then the next load goes.
        resp_lat = 5;
        present(mk(MEN_L, SZ_W, 1'b0, 32'h0), 32'h100, 1'b0);
        @(negedge clk);
        chk("flush_req_issued", {63'h0, dreq_valid}, 64'h1);
        @(posedge clk);
        #2;
        pipeline_flush = 1'b1;
        @(negedge clk);
        chk("flush_no_wb", {63'h0, mem_wb_valid}, 64'h0);
        @(posedge clk);
        #2;
        pipeline_flush = 1'b0;
        resp_lat       = 1;
        issue(mk(MEN_L, SZ_W, 1'b0, 32'h0), 32'h300, st, rd, seen);
        chk("drain_next_after_resp", 64'(hs_cyc), 64'(prev_resp_cyc + 1));
        chk("drain_stalls", 64'(st), 64'd6);
        chk("drain_rdata", {32'h0, rd}, 64'h8001_7FFF);

        // Reset mid-access: the late response must be ignored.
        resp_lat = 3;
        present(mk(MEN_L, SZ_W, 1'b0, 32'h0), 32'h100, 1'b0);
        @(posedge clk);
        #2;
        reset         = 1'b1;
        exe_mem_valid = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", {61'h0, dreq_valid, mem_wb_valid, mem_stall_flg}, 64'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        wbv   = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_wb_valid || mem_stall_flg) wbv++;
        end
        chk("midreset_resp_ignored", 64'(wbv), 64'd0);
        @(posedge clk);
        #2;
        resp_lat = 1;
        issue(mk(MEN_X, SZ_W, 1'b0, 32'h0), 32'h0000_0042, st, rd, seen);
        issue(mk(MEN_L, SZ_W, 1'b0, 32'h0), 32'h300, st, rd, seen);
        chk("recover_rdata", {32'h0, rd}, 64'h8001_7FFF);

        repeat (3) @(negedge clk);
        chk("req_queue_empty", 64'(req_q.size()), 64'd0);
        chk("wb_queue_empty", 64'(wb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
